// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end; PC generation, ROM addressing, instruction register, jump bubble
// ports: clk, reset (async active-low); stall holds pc/ir; jump_req/jump_addr redirect fetch when ir_valid;
//        rom_data in (1-cycle ROM); rom_addr = next pc; pc, ir, ir_pc, ir_valid, flush_pipeline, prev_flush out
module fetch_stage #(
  parameter int PC_WIDTH = 8,
  parameter int IR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                jump_req,
  input  logic [PC_WIDTH-1:0] jump_addr,
  input  logic [IR_WIDTH-1:0] rom_data,
  output logic [PC_WIDTH-1:0] rom_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [IR_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0] ir_pc,
  output logic                ir_valid,
  output logic                flush_pipeline,
  output logic                prev_flush
);
  logic rom_valid;
  logic jump_taken;
  always_comb begin
    jump_taken = jump_req & ir_valid;
    rom_addr = jump_taken ? jump_addr : (stall || !rom_valid) ? pc : pc + PC_WIDTH'(1);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= RESET_VECTOR;
      rom_valid <= 1'b0;
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
      flush_pipeline <= 1'b0;
      prev_flush <= 1'b0;
    end else begin
      pc <= rom_addr;
      rom_valid <= 1'b1;
      prev_flush <= flush_pipeline;
      flush_pipeline <= jump_taken;
      if (jump_taken) begin
        ir <= '0;
        ir_valid <= 1'b0;
      end else if (!stall) begin
        ir <= rom_data;
        ir_pc <= pc;
        ir_valid <= rom_valid;
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed check of fetch_stage against an instruction-stream model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  logic jump_req = 1'b0;
  logic [7:0] jump_addr = '0;
  logic [7:0] rom_data = '0;
  logic [7:0] rom_addr, pc, ir, ir_pc;
  logic ir_valid, flush_pipeline, prev_flush;
  int tests = 0;
  int errs = 0;
  logic [7:0] m_next, m_ir, m_ir_pc;
  bit m_ready, m_valid, m_flush, m_prev, m_irk;
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_addr ^ 8'hA5;
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .jump_req(jump_req), .jump_addr(jump_addr),
    .rom_data(rom_data), .rom_addr(rom_addr), .pc(pc), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .flush_pipeline(flush_pipeline), .prev_flush(prev_flush)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_clear();
    m_next = 8'h00;
    m_ready = 0;
    m_valid = 0;
    m_flush = 0;
    m_prev = 0;
    m_ir = 8'h00;
    m_ir_pc = 8'h00;
    m_irk = 1;
  endtask
  // the stream model: next word to deliver, whether the ROM output is meaningful yet, and the flush pair
  task automatic m_edge(input bit s, input bit j, input logic [7:0] ja);
    m_prev = m_flush;
    if (j && m_valid) begin
      m_valid = 0;
      m_flush = 1;
      m_next = ja;
      m_ir = 8'h00;
      m_irk = 1;
    end else if (s) begin
      m_flush = 0;
    end else begin
      m_flush = 0;
      m_valid = m_ready;
      m_ir_pc = m_next;
      m_ir = m_next ^ 8'hA5;
      m_irk = m_ready;
      if (m_ready) m_next = m_next + 8'h01;
    end
    m_ready = 1;
  endtask
  task automatic check_addr();
    logic [7:0] e;
    e = (jump_req && m_valid) ? jump_addr : (stall || !m_ready) ? m_next : m_next + 8'h01;
    check("rom_addr", rom_addr, reset ? e : 8'h00);
  endtask
  task automatic check_outs();
    check("pc", pc, m_next);
    check("ir_valid", ir_valid, m_valid);
    check("flush", flush_pipeline, m_flush);
    check("prev_flush", prev_flush, m_prev);
    check("ir_pc", ir_pc, m_ir_pc);
    if (m_irk) check("ir", ir, m_ir);
  endtask
  task automatic step(input bit s, input bit j, input logic [7:0] ja);
    stall = s;
    jump_req = j;
    jump_addr = ja;
    #1 check_addr();
    @(posedge clk);
    if (!reset) m_clear();
    else m_edge(s, j, ja);
    #1 check_outs();
  endtask
  task automatic run_until(input logic [7:0] a);
    for (int i = 0; i < 600 && !(m_valid && m_ir_pc == a); i++) step(0, 0, 8'h00);
    check("reach", ir_pc, a);
  endtask
  task automatic pulse_reset();
    reset = 1'b0;
    #1 m_clear();
    check_outs();
    check_addr();
    repeat (3) step(0, 0, 8'h00);
    reset = 1'b1;
  endtask
  initial begin
    m_clear();
    #2 check_outs();
    check_addr();
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    reset = 1'b1;
    step(0, 0, 8'h00);
    check("e1_pc", pc, 8'h00);
    step(0, 0, 8'h00);
    check("e2_ir", ir, 8'hA5);
    check("e2_valid", ir_valid, 1);
    step(0, 0, 8'h00);
    check("e3_ir", ir, 8'hA4);
    check("e3_ir_pc", ir_pc, 8'h01);
    run_until(8'h05);
    step(0, 1, 8'h3C);
    check("j_bubble", ir_valid, 0);
    check("j_flush", flush_pipeline, 1);
    step(0, 1, 8'h3C);
    check("j_ir", ir, 8'h99);
    check("j_ir_pc", ir_pc, 8'h3C);
    check("j_prev", prev_flush, 1);
    check("j_noflush", flush_pipeline, 0);
    step(0, 0, 8'h00);
    check("j_once", prev_flush, 0);
    run_until(8'h10);
    check("s_ir", ir, 8'hB5);
    repeat (3) begin
      step(1, 0, 8'h00);
      check("s_pc", pc, 8'h11);
      check("s_hold", ir, 8'hB5);
    end
    step(0, 0, 8'h00);
    check("s_rel_ir", ir, 8'hB4);
    check("s_rel_pc", ir_pc, 8'h11);
    step(1, 1, 8'h77);
    check("sj_pc", pc, 8'h77);
    check("sj_bubble", ir_valid, 0);
    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    check("sj_ir", ir, 8'h77 ^ 8'hA5);
    step(0, 1, 8'hFC);
    run_until(8'hFF);
    check("w_ir", ir, 8'h5A);
    step(0, 0, 8'h00);
    check("w_ir2", ir, 8'hA5);
    check("w_ir_pc", ir_pc, 8'h00);
    step(1, 0, 8'h00);
    pulse_reset();
    step(0, 0, 8'h00);
    check("r_pc", pc, 8'h00);
    step(0, 0, 8'h00);
    check("r_ir", ir, 8'hA5);
    check("r_valid", ir_valid, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
